axi_extraction_s_axi_regs: RTL and testbench

AXI4-Lite responder (slave) holding the software-visible control/status registers of the `axi_extraction` IP. It is the counterpart to the AXI4-Lite master agent that drives the `S00_AXI` port of the block design. It accepts single-beat writes and reads, applies byte strobes, and returns OKAY/SLVERR. It exports the register contents and per-register write pulses to the extraction datapath.

---
 rtl/axi_extraction_regs_pkg.sv | 37 +++
 rtl/axi_extraction_s_axi_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_extraction_s_axi_regs.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_extraction_regs_pkg.sv
// Shared definitions for the axi_extraction register block: response codes,
// FSM state types, register width and the address decode helper.
package axi_extraction_regs_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef struct packed {
        logic        valid;
        logic [29:0] index;
    } decode_t;

    // Word index is the byte address divided by four; the low two address
    // bits never select anything. Indices past the register file are invalid.
    function automatic decode_t decode_addr(input logic [31:0] addr,
                                           input int unsigned num_regs);
        decode_t d;
        d.index = 30'(addr >> 2);
        d.valid = ({2'b00, d.index} < num_regs);
        return d;
    endfunction

endpackage

// File: rtl/axi_extraction_s_axi_regs.sv
// AXI4-Lite responder holding the axi_extraction control/status registers.
// Single outstanding write, single outstanding read, byte strobes honoured,
// out-of-range addresses answered with SLVERR.
module axi_extraction_s_axi_regs
    import axi_extraction_regs_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter int          NUM_REGS           = 4,
    parameter logic [31:0] RESET_VALUE        = 32'h0
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,

    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,

    output logic [NUM_REGS*REG_WIDTH-1:0]     reg_out,
    output logic [NUM_REGS-1:0]               reg_wr_pulse
);

    localparam int NUM_BYTES = REG_WIDTH / 8;

    w_state_t w_state;
    w_state_t w_state_next;
    r_state_t r_state;
    r_state_t r_state_next;

    logic                          active_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [REG_WIDTH-1:0]          w_data_q;
    logic [NUM_BYTES-1:0]          w_strb_q;
    logic [1:0]                    bresp_q;
    logic [REG_WIDTH-1:0]          rdata_q;
    logic [1:0]                    rresp_q;
    logic [NUM_REGS-1:0]           wr_pulse_q;
    logic [REG_WIDTH-1:0]          regs [NUM_REGS];

    logic                          aw_ready;
    logic                          w_ready;
    logic                          ar_ready;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] commit_addr;
    logic [REG_WIDTH-1:0]          commit_data;
    logic [NUM_BYTES-1:0]          commit_strb;
    decode_t                       wdec;
    decode_t                       rdec;
    logic [REG_WIDTH-1:0]          rd_word;

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Readys come only from registered state, and stay low until the
    // first clock edge after reset has been released.
    assign aw_ready = active_q && ((w_state == W_IDLE) || (w_state == W_HAVE_W));
    assign w_ready  = active_q && ((w_state == W_IDLE) || (w_state == W_HAVE_AW));
    assign ar_ready = active_q && (r_state == R_IDLE);

    assign aw_hs = S_AXI_AWVALID && aw_ready;
    assign w_hs  = S_AXI_WVALID  && w_ready;
    assign ar_hs = S_AXI_ARVALID && ar_ready;

    // The half of a write that arrived first is taken from its holding
    // register; the half arriving now comes straight off the bus.
    assign commit_addr = (w_state == W_HAVE_AW) ? aw_addr_q : S_AXI_AWADDR;
    assign commit_data = (w_state == W_HAVE_W)  ? w_data_q  : S_AXI_WDATA;
    assign commit_strb = (w_state == W_HAVE_W)  ? w_strb_q  : S_AXI_WSTRB;

    assign wdec = decode_addr(32'(commit_addr), NUM_REGS);
    assign rdec = decode_addr(32'(S_AXI_ARADDR), NUM_REGS);

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse  = wr_pulse_q;

    // State registers for both channel FSMs plus the out-of-reset flag.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            active_q <= 1'b0;
        end else begin
            w_state  <= w_state_next;
            r_state  <= r_state_next;
            active_q <= 1'b1;
        end
    end

    // Write FSM next state and the commit strobe (both halves present).
    always_comb begin
        w_state_next = w_state;
        commit       = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end else if (aw_hs) begin
                    w_state_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_state_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Read FSM next state: one AR accepted, then hold the beat until RREADY.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)        r_state_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Capture whichever write half arrives alone, and the write response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (w_state == W_IDLE && aw_hs && !w_hs) begin
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_state == W_IDLE && w_hs && !aw_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bresp_q <= wdec.valid ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register file: strobed byte writes on commit, one-cycle write pulse.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (commit && wdec.valid) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wdec.index == 30'(i)) begin
                        wr_pulse_q[i] <= 1'b1;
                        for (int b = 0; b < NUM_BYTES; b++) begin
                            if (commit_strb[b]) begin
                                regs[i][8*b +: 8] <= commit_data[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Read mux over the register file; out-of-range indices read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rdec.valid && rdec.index == 30'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    // Read beat is registered at the AR handshake, so a same-edge write
    // to the same register is not yet visible to it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_word;
            rresp_q <= rdec.valid ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Flatten the register file for the extraction datapath.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[REG_WIDTH*i +: REG_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_axi_extraction_s_axi_regs.sv
// Self-checking bench for axi_extraction_s_axi_regs: directed scenarios plus
// random traffic checked against a word-array model of the register file.
module tb_axi_extraction_s_axi_regs;

    localparam int AW = 5;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0]    reg_wr_pulse;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [NR];
    int          last_aw_cycle;
    int          last_w_cycle;

    axi_extraction_s_axi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR),
        .RESET_VALUE(32'h0)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .reg_out(reg_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Register-file model: word address = byte address / 4, strobed bytes replace.
    task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] exp_resp,
                               output logic [NR-1:0] exp_pulse);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
            exp_resp  = 2'b00;
            exp_pulse = NR'(1 << idx);
        end else begin
            exp_resp  = 2'b10;
            exp_pulse = '0;
        end
    endtask

    function automatic logic [33:0] model_read(input logic [AW-1:0] addr);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NR) return {2'b00, model[idx]};
        return {2'b10, 32'h0};
    endfunction

    // One write; lead > 0 puts W ahead of AW by that many cycles, lead < 0
    // puts AW ahead. BREADY is held low for hold_b cycles after the commit.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int lead, input int hold_b,
                                 output logic [1:0] resp, output logic [NR-1:0] pulses);
        int   aw_start;
        int   w_start;
        bit   aw_done;
        bit   w_done;
        bit   aw_hs;
        bit   w_hs;
        logic [1:0] first_resp;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        bready = 1'b0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        resp    = 2'bxx;
        pulses  = '0;
        for (int cyc = 0; cyc < 20 && !(aw_done && w_done); cyc++) begin
            if (!aw_done && cyc >= aw_start) awvalid = 1'b1;
            if (!w_done && cyc >= w_start)   wvalid  = 1'b1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; last_aw_cycle = cyc; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; last_w_cycle  = cyc; end
        end
        if (!(aw_done && w_done)) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            checkOutput("write_handshake_timeout", 0, 1);
            return;
        end
        pulses     = reg_wr_pulse;
        first_resp = bresp;
        for (int i = 0; i < hold_b; i++) begin
            awvalid = 1'b1;
            checkOutput("bvalid_held", bvalid, 1'b1);
            checkOutput("bresp_stable", bresp, first_resp);
            checkOutput("awready_blocked", awready, 1'b0);
            checkOutput("wready_blocked", wready, 1'b0);
            @(posedge clk); #1;
            pulses = pulses | reg_wr_pulse;
        end
        awvalid = 1'b0;
        checkOutput("bvalid", bvalid, 1'b1);
        resp   = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checkOutput("bvalid_cleared", bvalid, 1'b0);
        if (hold_b > 0) checkOutput("awready_after_b", awready, 1'b1);
    endtask

    // One read; RREADY is held low for hold_r cycles after the beat appears.
    task automatic read_back(input logic [AW-1:0] addr, input int hold_r,
                             output logic [31:0] data, output logic [1:0] resp);
        bit done;
        bit hs;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b0;
        done    = 1'b0;
        data    = 'x;
        resp    = 'x;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) done = 1'b1;
        end
        arvalid = 1'b0;
        if (!done) begin
            checkOutput("read_handshake_timeout", 0, 1);
            return;
        end
        checkOutput("rvalid", rvalid, 1'b1);
        data = rdata;
        resp = rresp;
        for (int i = 0; i < hold_r; i++) begin
            @(posedge clk); #1;
            checkOutput("rdata_stable", {rvalid, rresp, rdata}, {1'b1, resp, data});
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checkOutput("rvalid_cleared", rvalid, 1'b0);
    endtask

    initial begin
        logic [1:0]    resp;
        logic [1:0]    exp_resp;
        logic [NR-1:0] pulses;
        logic [NR-1:0] exp_pulse;
        logic [31:0]   data;
        logic [33:0]   exp_rd;
        logic [AW-1:0] addr;
        logic [3:0]    strb;
        logic [31:0]   old_reg0;

        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_readys", {awready, wready, arready}, 3'b000);
        checkOutput("reset_valids", {bvalid, rvalid}, 2'b00);
        checkOutput("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
        checkOutput("reset_pulse", reg_wr_pulse, '0);
        checkOutput("reset_regs", reg_out, model_flat());
        aresetn = 1'b1;
        @(posedge clk); #1;
        checkOutput("readys_after_release", {awready, wready, arready}, 3'b111);

        // Four full-word writes then four reads
        for (int i = 0; i < 4; i++) begin
            addr = AW'(4 * i);
            model_write(addr, 32'(i + 1), 4'hF, exp_resp, exp_pulse);
            applyStimulus(addr, 32'(i + 1), 4'hF, 0, 0, resp, pulses);
            checkOutput("seq_bresp", resp, exp_resp);
            checkOutput("seq_pulse", pulses, exp_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            read_back(AW'(4 * i), 0, data, resp);
            checkOutput("seq_rdata", data, 32'(i + 1));
            checkOutput("seq_rresp", resp, 2'b00);
        end
        checkOutput("seq_reg_out", reg_out, {32'd4, 32'd3, 32'd2, 32'd1});

        // W arrives three cycles ahead of AW
        model_write(5'h04, 32'hDEADBEEF, 4'hF, exp_resp, exp_pulse);
        applyStimulus(5'h04, 32'hDEADBEEF, 4'hF, 3, 0, resp, pulses);
        checkOutput("wfirst_w_cycle", last_w_cycle, 0);
        checkOutput("wfirst_aw_cycle", last_aw_cycle, 3);
        checkOutput("wfirst_pulse", pulses, 4'b0010);
        checkOutput("wfirst_bresp", resp, 2'b00);
        checkOutput("wfirst_reg_out", reg_out, model_flat());

        // Byte strobe merge
        model_write(5'h00, 32'h00000001, 4'hF, exp_resp, exp_pulse);
        applyStimulus(5'h00, 32'h00000001, 4'hF, -2, 0, resp, pulses);
        model_write(5'h00, 32'hAABBCCDD, 4'b0010, exp_resp, exp_pulse);
        applyStimulus(5'h00, 32'hAABBCCDD, 4'b0010, 0, 0, resp, pulses);
        read_back(5'h00, 1, data, resp);
        checkOutput("strobe_rdata", data, 32'h0000CC01);

        // Out-of-range address
        applyStimulus(5'h10, 32'h12345678, 4'hF, 0, 0, resp, pulses);
        checkOutput("oor_bresp", resp, 2'b10);
        checkOutput("oor_pulse", pulses, '0);
        checkOutput("oor_reg_out", reg_out, model_flat());
        read_back(5'h10, 0, data, resp);
        checkOutput("oor_rdata", data, 32'h0);
        checkOutput("oor_rresp", resp, 2'b10);

        // Response back-pressure
        model_write(5'h08, 32'hCAFEF00D, 4'hF, exp_resp, exp_pulse);
        applyStimulus(5'h08, 32'hCAFEF00D, 4'hF, 0, 5, resp, pulses);
        checkOutput("bp_bresp", resp, exp_resp);
        checkOutput("bp_pulse", pulses, exp_pulse);
        checkOutput("bp_reg_out", reg_out, model_flat());

        // Random traffic against the model
        for (int n = 0; n < 30; n++) begin
            addr = AW'($urandom_range(0, 31));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                model_write(addr, data, strb, exp_resp, exp_pulse);
                applyStimulus(addr, data, strb, $urandom_range(0, 6) - 3, $urandom_range(0, 2),
                              resp, pulses);
                checkOutput("rand_bresp", resp, exp_resp);
                checkOutput("rand_pulse", pulses, exp_pulse);
                checkOutput("rand_reg_out", reg_out, model_flat());
            end else begin
                exp_rd = model_read(addr);
                read_back(addr, $urandom_range(0, 2), data, resp);
                checkOutput("rand_rdata", data, exp_rd[31:0]);
                checkOutput("rand_rresp", resp, exp_rd[33:32]);
            end
        end

        // Same-edge read and write of register 0, then reset with both
        // responses pending
        old_reg0 = model[0];
        data     = $urandom;
        awaddr = 5'h00; wdata = data; wstrb = 4'hF; araddr = 5'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(5'h00, data, 4'hF, exp_resp, exp_pulse);
        checkOutput("both_pending", {bvalid, rvalid}, 2'b11);
        checkOutput("same_edge_old_value", rdata, old_reg0);
        checkOutput("same_edge_new_reg", reg_out[31:0], data);
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        checkOutput("midreset_valids", {bvalid, rvalid}, 2'b00);
        checkOutput("midreset_regs", reg_out, model_flat());
        checkOutput("midreset_readys", {awready, wready, arready}, 3'b000);
        checkOutput("midreset_pulse_data", {reg_wr_pulse, bresp, rresp, rdata}, '0);
        @(posedge clk); #1;
        read_back(5'h00, 0, data, resp);
        checkOutput("post_reset_read", {resp, data}, 34'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
